// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL supervisor / reset sequencer: state encoding
// and a helper used to size the shared timer.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCKED into the
// oscillator domain; resets to "not locked".
module lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for a stable lock, then releases
// the domain resets one after another; retries on timeout, restarts on loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int N_OUT          = 3,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_STABLE    = 64,
    parameter int STAGE_DELAY    = 256,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               glbl_rst_n,
    input  logic               pll_lock,
    input  logic               force_rst,
    output logic               pll_rst,
    output logic [N_OUT-1:0]   dom_rst,
    output logic               ready,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   lock_loss_cnt,
    output logic [CNT_W-1:0]   timeout_cnt
);

    localparam int TMR_W = $clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, STAGE_DELAY));
    localparam int STG_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             lock_s;
    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic             pll_rst_q, pll_rst_d;
    logic [N_OUT-1:0] dom_rst_q, dom_rst_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             restart;

    lock_sync u_lock_sync (
        .clk   (clk),
        .rst_n (glbl_rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        stage_d    = stage_q;
        pll_rst_d  = pll_rst_q;
        dom_rst_d  = dom_rst_q;
        ready_d    = ready_q;
        loss_cnt_d = loss_cnt_q;
        to_cnt_d   = to_cnt_q;
        restart    = force_rst;

        // force_rst bypasses the state logic entirely, so no counter can move.
        if (!force_rst) begin
            case (state_q)
                ST_PLL_RST: begin
                    if (timer_q == TMR_W'(PLL_RST_CYCLES - 1)) begin
                        state_d   = ST_WAIT_LOCK;
                        timer_d   = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        if (to_cnt_q != CNT_MAX) to_cnt_d = to_cnt_q + CNT_W'(1);
                        restart = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == TMR_W'(LOCK_STABLE - 1)) begin
                        state_d = ST_RELEASE;
                        timer_d = '0;
                        stage_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        if (loss_cnt_q != CNT_MAX) loss_cnt_d = loss_cnt_q + CNT_W'(1);
                        restart = 1'b1;
                    end else if (timer_q == TMR_W'(STAGE_DELAY - 1)) begin
                        // Timer wraps per stage; stage_q selects the next bit to drop.
                        timer_d            = '0;
                        dom_rst_d[stage_q] = 1'b0;
                        stage_d            = stage_q + STG_W'(1);
                        if (stage_q == STG_W'(N_OUT - 1)) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        if (loss_cnt_q != CNT_MAX) loss_cnt_d = loss_cnt_q + CNT_W'(1);
                        restart = 1'b1;
                    end
                end
                default: restart = 1'b1;
            endcase
        end

        if (restart) begin
            state_d   = ST_PLL_RST;
            timer_d   = '0;
            stage_d   = '0;
            pll_rst_d = 1'b1;
            dom_rst_d = '1;
            ready_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state_q    <= ST_PLL_RST;
            timer_q    <= '0;
            stage_q    <= '0;
            pll_rst_q  <= 1'b1;
            dom_rst_q  <= '1;
            ready_q    <= 1'b0;
            loss_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            stage_q    <= stage_d;
            pll_rst_q  <= pll_rst_d;
            dom_rst_q  <= dom_rst_d;
            ready_q    <= ready_d;
            loss_cnt_q <= loss_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign dom_rst       = dom_rst_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign timeout_cnt   = to_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios with literal expectations,
// then randomized lock/force/reset traffic checked every cycle against a model.
module tb_pll_reset_sequencer;

    localparam int N_OUT   = 3;
    localparam int PRC     = 4;
    localparam int LT      = 32;
    localparam int LS      = 8;
    localparam int SD      = 10;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk        = 1'b0;
    logic             glbl_rst_n = 1'b0;
    logic             pll_lock   = 1'b0;
    logic             force_rst  = 1'b0;
    logic             pll_rst;
    logic [N_OUT-1:0] dom_rst;
    logic             ready;
    logic [2:0]       state;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    pll_reset_sequencer #(
        .N_OUT          (N_OUT),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LT),
        .LOCK_STABLE    (LS),
        .STAGE_DELAY    (SD),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .glbl_rst_n    (glbl_rst_n),
        .pll_lock      (pll_lock),
        .force_rst     (force_rst),
        .pll_rst       (pll_rst),
        .dom_rst       (dom_rst),
        .ready         (ready),
        .state         (state),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number plus cycles spent in that phase.
    int   m_phase = 0;
    int   m_e     = 0;
    int   m_to    = 0;
    int   m_ll    = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;

    task automatic model_step(input logic ls, input logic frc);
        if (frc) begin
            m_phase = 0;
            m_e     = 0;
        end else begin
            case (m_phase)
                0: if (m_e == PRC - 1) begin m_phase = 1; m_e = 0; end
                   else m_e++;
                1: if (ls) begin m_phase = 2; m_e = 0; end
                   else if (m_e == LT - 1) begin
                       if (m_to < CNT_MAX) m_to++;
                       m_phase = 0; m_e = 0;
                   end else m_e++;
                2: if (!ls) begin m_phase = 1; m_e = 0; end
                   else if (m_e == LS - 1) begin m_phase = 3; m_e = 0; end
                   else m_e++;
                3, 4: if (!ls) begin
                       if (m_ll < CNT_MAX) m_ll++;
                       m_phase = 0; m_e = 0;
                   end else if (m_phase == 3) begin
                       m_e++;
                       if (m_e == SD * N_OUT) m_phase = 4;
                   end
                default: m_phase = 0;
            endcase
        end
    endtask

    always @(posedge clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            m_phase = 0; m_e = 0; m_to = 0; m_ll = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            logic ls;
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_lock;
            model_step(ls, force_rst);
        end
    end

    always @(negedge clk) begin : cmp
        logic [N_OUT-1:0] exp_dom;
        for (int k = 0; k < N_OUT; k++)
            exp_dom[k] = !(m_phase == 4 || (m_phase == 3 && m_e >= SD * (k + 1)));
        check("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
        check("dom_rst", 32'(dom_rst), 32'(exp_dom));
        check("ready", 32'(ready), 32'(m_phase == 4));
        check("state", 32'(state), 32'(m_phase));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_ll));
        check("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        glbl_rst_n = 1'b0;
        pll_lock   = 1'b0;
        force_rst  = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_dom_rst", 32'(dom_rst), 32'd7);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        step();
        glbl_rst_n = 1'b1;
    endtask

    task automatic wait_state(input int s, input int limit, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (32'(state) != s && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state), 32'(s));
    endtask

    task automatic run_nominal();
        int n;
        do_reset();
        n = 0;
        @(negedge clk);
        while (pll_rst && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("nom_pll_rst_width", 32'(n), 32'd4);
        repeat (16) step();
        pll_lock = 1'b1;
        wait_state(3, 200, "nom_reach_release");
        n = 0;
        for (int k = 0; k < N_OUT; k++) begin
            while (dom_rst[k] && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("nom_stage_release", 32'(n), 32'(SD * (k + 1)));
        end
        check("nom_ready", 32'(ready), 32'd1);
        check("nom_state_run", 32'(state), 32'd4);
        check("nom_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        check("nom_timeout_cnt", 32'(timeout_cnt), 32'd0);
    endtask

    task automatic run_timeout();
        logic [CNT_W-1:0] exp_q[$];
        int cyc, last_rise, rises;
        logic prev;
        do_reset();
        for (int i = 1; i <= 5; i++) exp_q.push_back(CNT_W'((i < CNT_MAX) ? i : CNT_MAX));
        cyc = 0; last_rise = -1; rises = 0; prev = 1'b1;
        while (rises < 5 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pll_rst && !prev) begin
                check("to_retry_cnt", 32'(timeout_cnt), 32'(exp_q.pop_front()));
                if (last_rise >= 0) check("to_retry_period", 32'(cyc - last_rise), 32'd36);
                last_rise = cyc;
                rises++;
            end
            if (!pll_rst && prev && last_rise >= 0)
                check("to_pulse_width", 32'(cyc - last_rise), 32'd4);
            prev = pll_rst;
        end
        check("to_retries_seen", 32'(rises), 32'd5);
    endtask

    task automatic run_glitch();
        logic [2:0] sq[$];
        int glitches, run, last_run;
        do_reset();
        wait_state(1, 20, "gl_wait_lock");
        for (int c = 0; c < 60; c++) begin
            step();
            if (c == 0 || c == 6) pll_lock = 1'b1;
            else if (c == 5) pll_lock = 1'b0;
            @(negedge clk);
            sq.push_back(state);
        end
        glitches = 0; run = 0; last_run = 0;
        foreach (sq[i]) begin
            if (sq[i] == 3'd2) run++;
            else begin
                if (run > 0 && sq[i] == 3'd1) glitches++;
                if (run > 0 && sq[i] == 3'd3) last_run = run;
                run = 0;
            end
        end
        check("gl_back_to_wait", 32'(glitches), 32'd1);
        check("gl_final_stable_run", 32'(last_run), 32'd8);
        check("gl_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        check("gl_timeout_cnt", 32'(timeout_cnt), 32'd0);
    endtask

    task automatic run_loss();
        int n;
        wait_state(4, 100, "loss_reach_run");
        step();
        pll_lock = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (ready && n < 20);
        check("loss_latency", 32'(n), 32'd3);
        check("loss_dom_rst", 32'(dom_rst), 32'd7);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
        check("loss_state", 32'(state), 32'd0);
        check("loss_cnt", 32'(lock_loss_cnt), 32'd1);
        pll_lock = 1'b1;
        wait_state(4, 200, "loss_relock_run");
        check("loss_relock_ready", 32'(ready), 32'd1);
    endtask

    task automatic run_force();
        int n;
        step();
        pll_lock = 1'b0;
        step();
        step();
        force_rst = 1'b1;
        step();
        check("frc_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        check("frc_dom_rst", 32'(dom_rst), 32'd7);
        check("frc_pll_rst", 32'(pll_rst), 32'd1);
        pll_lock = 1'b1;
        n = 0;
        repeat (100) begin
            step();
            if (pll_rst === 1'b1 && state === 3'd0) n++;
        end
        check("frc_hold_cycles", 32'(n), 32'd100);
        force_rst = 1'b0;
        wait_state(4, 200, "frc_resequence_run");
        check("frc_loss_cnt_after", 32'(lock_loss_cnt), 32'd1);
    endtask

    task automatic run_random();
        int r;
        step();
        repeat (150) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                glbl_rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                glbl_rst_n = 1'b1;
            end else if (r < 15) begin
                force_rst = 1'b1;
                repeat ($urandom_range(1, 6)) step();
                force_rst = 1'b0;
            end else if (r < 45) begin
                pll_lock = 1'b0;
                repeat ($urandom_range(1, 40)) step();
            end else begin
                pll_lock = 1'b1;
                repeat ($urandom_range(1, 80)) step();
            end
        end
    endtask

    initial begin
        run_nominal();
        run_timeout();
        run_glitch();
        run_loss();
        run_force();
        run_random();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
